// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Two-requester front end for one shared combinational ALU. An idle
//   arbiter grants one requester. A single requester gets the grant
//   directly. When both request, a round-robin pointer picks the winner.
//   The arbiter captures that requester's opcode and operands, registers
//   the ALU result one cycle later, and holds it as a response until the
//   owner consumes it.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req{0,1}_valid/_ready      request handshake per requester
//   req{0,1}_op/_a/_b          opcode and operands per requester
//   alu_a, alu_b, alu_op       operands/opcode driven to the shared ALU
//   alu_c, alu_flag            ALU result and branch flag (combinational)
//   rsp{0,1}_valid/_ready      response handshake per requester
//   rsp_c, rsp_flag, rsp_err   shared response payload
//   busy                       high whenever an operation is in flight
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_flag,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_c,
  output logic              rsp_flag,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Opcodes above this value are illegal and produce an error response.
  localparam logic [OP_W-1:0] OP_LAST_LEGAL = OP_W'(12);

  state_t            state_q, state_d;
  logic              rr_q, rr_d;          // requester that wins a tie
  logic              owner_q, owner_d;    // requester being served
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] rsp_c_q, rsp_c_d;
  logic              rsp_flag_q, rsp_flag_d;
  logic              rsp_err_q, rsp_err_d;

  logic              grant_valid;
  logic              grant_id;
  logic              owner_rsp_ready;

  // A tie goes to rr_q. Otherwise the grant goes to whichever requester is
  // valid. grant_id is don't-care when nobody requests.
  assign grant_valid = req0_valid | req1_valid;
  assign grant_id    = (req0_valid & req1_valid) ? rr_q : ~req0_valid;

  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  // NOTE: combinational logic uses blocking '='. Every signal gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_c_d    = rsp_c_q;
    rsp_flag_d = rsp_flag_q;
    rsp_err_d  = rsp_err_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        req0_ready = grant_valid & ~grant_id;
        req1_ready = grant_valid &  grant_id;
        // The granted requester is valid by construction, so a grant is
        // an accept.
        if (grant_valid) begin
          owner_d = grant_id;
          rr_d    = ~grant_id;
          op_d    = grant_id ? req1_op : req0_op;
          a_d     = grant_id ? req1_a  : req0_a;
          b_d     = grant_id ? req1_b  : req0_b;
          state_d = EXEC;
        end
      end

      EXEC: begin
        if (op_q > OP_LAST_LEGAL) begin
          rsp_c_d    = '0;
          rsp_flag_d = 1'b0;
          rsp_err_d  = 1'b1;
        end else begin
          rsp_c_d    = alu_c;
          rsp_flag_d = alu_flag;
          rsp_err_d  = 1'b0;
        end
        state_d = RESP;
      end

      RESP: begin
        // The non-owner's rsp_ready plays no part here.
        if (owner_rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<='. The datapath registers
  // are also reset, because the ALU inputs and the response payload are
  // visible outputs that must read zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      owner_q    <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_c_q    <= '0;
      rsp_flag_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_c_q    <= rsp_c_d;
      rsp_flag_q <= rsp_flag_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign rsp_c      = rsp_c_q;
  assign rsp_flag   = rsp_flag_q;
  assign rsp_err    = rsp_err_q;
  assign rsp0_valid = (state_q == RESP) & ~owner_q;
  assign rsp1_valid = (state_q == RESP) &  owner_q;
  assign busy       = (state_q != IDLE);

endmodule
